// File: rtl/axilite_if.sv
// AXI-Lite bus bundle: five independent channels, each a valid/ready handshake.
// A beat transfers on a rising edge where valid and ready are both high.
interface axilite_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_regfile.sv
// AXI-Lite register bank: NUM_REGS byte-strobed registers, SLVERR on out-of-range
// word indices, register contents and per-register write pulses exported.
module axilite_regfile #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axilite_if.slave                       s_axilite,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;

    logic                  aw_full;
    logic                  w_full;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         wstrb_q;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic             aw_in_range;
    logic             ar_in_range;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_addr_lsbs;

    // AW and W are captured independently; the write commits once both are held,
    // and neither channel reopens until the B response has been taken.
    assign s_axilite.awready = !rst && !aw_full && !s_axilite.bvalid;
    assign s_axilite.wready  = !rst && !w_full  && !s_axilite.bvalid;
    assign s_axilite.arready = !rst && !s_axilite.rvalid;

    assign aw_hs  = s_axilite.awvalid && s_axilite.awready;
    assign w_hs   = s_axilite.wvalid  && s_axilite.wready;
    assign ar_hs  = s_axilite.arvalid && s_axilite.arready;
    assign commit = aw_full && w_full;

    assign ar_idx      = s_axilite.araddr[ADDR_WIDTH-1:2];
    assign aw_in_range = int'(aw_idx_q) < NUM_REGS;
    assign ar_in_range = int'(ar_idx) < NUM_REGS;

    assign unused_addr_lsbs = ^{s_axilite.awaddr[1:0], s_axilite.araddr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full          <= 1'b0;
            w_full           <= 1'b0;
            aw_idx_q         <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            s_axilite.bvalid <= 1'b0;
            s_axilite.bresp  <= 2'b00;
            s_axilite.rvalid <= 1'b0;
            s_axilite.rresp  <= 2'b00;
            s_axilite.rdata  <= '0;
            reg_q            <= {NUM_REGS{RESET_VAL}};
            wr_pulse         <= '0;
        end else begin
            wr_pulse <= '0;

            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= s_axilite.awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                wdata_q <= s_axilite.wdata;
                wstrb_q <= s_axilite.wstrb;
            end

            if (s_axilite.bvalid && s_axilite.bready) begin
                s_axilite.bvalid <= 1'b0;
            end

            if (commit) begin
                aw_full          <= 1'b0;
                w_full           <= 1'b0;
                s_axilite.bvalid <= 1'b1;
                s_axilite.bresp  <= aw_in_range ? 2'b00 : 2'b10;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (aw_idx_q == IDX_W'(i)) begin
                        wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (wstrb_q[b]) begin
                                reg_q[i*DATA_WIDTH + 8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
            end

            if (s_axilite.rvalid && s_axilite.rready) begin
                s_axilite.rvalid <= 1'b0;
            end

            // Reads sample reg_q before any same-edge commit lands.
            if (ar_hs) begin
                s_axilite.rvalid <= 1'b1;
                s_axilite.rresp  <= ar_in_range ? 2'b00 : 2'b10;
                s_axilite.rdata  <= '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ar_idx == IDX_W'(i)) begin
                        s_axilite.rdata <= reg_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end
endmodule
